// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: ALU control codes, width defaults
// and the registered control payload.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_INVALID = 4'b1111
    } alu_ctrl_e;

    // Control bits carried through the EX/MEM slot alongside the data.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch_taken;
        logic illegal;
    } exmem_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_alu_core.sv
// Combinational ALU for the execute stage. The ovf_o port exists only when
// EX_OVF_TRAP_EN is defined.
module ex_mem_stage_alu_core
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
`ifdef EX_OVF_TRAP_EN
    output logic              ovf_o,
`endif
    output logic              illegal_o
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (ctrl_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = sum;
            ALU_SUB: result_o = diff;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, lt};
            default: illegal_o = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

`ifdef EX_OVF_TRAP_EN
    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        ovf_o = 1'b0;
        if (ctrl_i == ALU_ADD)
            ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
        else if (ctrl_i == ALU_SUB)
            ovf_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
    end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage with a registered EX/MEM slot and valid/ready handshake.
// Define EX_OVF_TRAP_EN to add ovf_o and suppress writeback on signed overflow.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              branch_i,
    input  logic [DATA_W-1:0] branch_target_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] branch_target_o,
`ifdef EX_OVF_TRAP_EN
    output logic              ovf_o,
`endif
    output logic              illegal_o
);

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_illegal;
    logic              alu_ok;
    logic              accept;

    logic              valid_d,  valid_q;
    logic [DATA_W-1:0] result_d, result_q;
    logic              zero_d,   zero_q;
    logic [DATA_W-1:0] store_d,  store_q;
    logic [REG_AW-1:0] rd_d,     rd_q;
    logic [DATA_W-1:0] target_d, target_q;
    exmem_ctrl_t       ctrl_d,   ctrl_q;
`ifdef EX_OVF_TRAP_EN
    logic              alu_ovf;
    logic              ovf_d,    ovf_q;
`endif

    ex_mem_stage_alu_core #(.DATA_W(DATA_W)) u_alu (
        .ctrl_i    (alu_ctrl_i),
        .a_i       (src1_i),
        .b_i       (src2_i),
        .result_o  (alu_result),
        .zero_o    (alu_zero),
`ifdef EX_OVF_TRAP_EN
        .ovf_o     (alu_ovf),
`endif
        .illegal_o (alu_illegal)
    );

    // The slot can take a new op whenever it is empty or being drained this cycle.
    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

`ifdef EX_OVF_TRAP_EN
    assign alu_ok = !alu_illegal && !alu_ovf;
`else
    assign alu_ok = !alu_illegal;
`endif

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        store_d  = store_q;
        rd_d     = rd_q;
        target_d = target_q;
        ctrl_d   = ctrl_q;
`ifdef EX_OVF_TRAP_EN
        ovf_d    = ovf_q;
`endif
        // Flush takes priority over both accept and drain.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d             = 1'b1;
            result_d            = alu_result;
            zero_d              = alu_zero;
            store_d             = store_data_i;
            rd_d                = rd_i;
            target_d            = branch_target_i;
            ctrl_d.reg_write    = reg_write_i && alu_ok;
            ctrl_d.mem_read     = mem_read_i && !alu_illegal;
            ctrl_d.mem_write    = mem_write_i && !alu_illegal;
            ctrl_d.branch_taken = branch_i && alu_zero && !alu_illegal;
            ctrl_d.illegal      = alu_illegal;
`ifdef EX_OVF_TRAP_EN
            ovf_d               = alu_ovf;
`endif
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            store_q  <= '0;
            rd_q     <= '0;
            target_q <= '0;
            ctrl_q   <= '0;
`ifdef EX_OVF_TRAP_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            target_q <= target_d;
            ctrl_q   <= ctrl_d;
`ifdef EX_OVF_TRAP_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign out_valid_o     = valid_q;
    assign result_o        = result_q;
    assign zero_o          = zero_q;
    assign store_data_o    = store_q;
    assign rd_o            = rd_q;
    assign branch_target_o = target_q;
    assign reg_write_o     = ctrl_q.reg_write;
    assign mem_read_o      = ctrl_q.mem_read;
    assign mem_write_o     = ctrl_q.mem_write;
    assign branch_taken_o  = ctrl_q.branch_taken;
    assign illegal_o       = ctrl_q.illegal;
`ifdef EX_OVF_TRAP_EN
    assign ovf_o           = ovf_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed cases followed by random traffic
// checked against an arithmetic reference model.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [3:0]    alu_ctrl_i;
    logic [DW-1:0] src1_i, src2_i, store_data_i, branch_target_i;
    logic [AW-1:0] rd_i, rd_o;
    logic          reg_write_i, mem_read_i, mem_write_i, branch_i;
    logic [DW-1:0] result_o, store_data_o, branch_target_o;
    logic          zero_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o, illegal_o;
`ifdef EX_OVF_TRAP_EN
    logic          ovf_o;
`endif

    ex_mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_ctrl_i(alu_ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
        .store_data_i(store_data_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .zero_o(zero_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .branch_taken_o(branch_taken_o),
        .branch_target_o(branch_target_o),
`ifdef EX_OVF_TRAP_EN
        .ovf_o(ovf_o),
`endif
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          valid, flush, ordy;
        logic [3:0]    ctrl;
        logic [DW-1:0] a, b, sd, tgt;
        logic [AW-1:0] rd;
        logic          rw, mr, mw, br;
    } stim_t;

    typedef struct {
        logic [DW-1:0] result, sd, tgt;
        logic [AW-1:0] rd;
        logic          zero, rw, mr, mw, bt, ill, ovf;
    } exp_t;

    exp_t exp_q[$];
    bit   slot_full;
    int   total, bad, accepted, delivered;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written straight from the operation definitions.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint sa, sb, wide;
        sa    = longint'($signed(s.a));
        sb    = longint'($signed(s.b));
        e.ill = 1'b0;
        e.ovf = 1'b0;
        case (s.ctrl)
            4'h0: e.result = s.a & s.b;
            4'h1: e.result = s.a | s.b;
            4'h2, 4'h6: begin
                wide     = (s.ctrl == 4'h2) ? sa + sb : sa - sb;
                e.result = wide[DW-1:0];
                e.ovf    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'h7: e.result = (sa < sb) ? 1 : 0;
            default: begin
                e.result = '0;
                e.ill    = 1'b1;
            end
        endcase
        e.zero = (e.result == 0);
        e.sd   = s.sd;
        e.tgt  = s.tgt;
        e.rd   = s.rd;
`ifdef EX_OVF_TRAP_EN
        e.rw   = s.rw && !e.ill && !e.ovf;
`else
        e.rw   = s.rw && !e.ill;
`endif
        e.mr   = s.mr && !e.ill;
        e.mw   = s.mw && !e.ill;
        e.bt   = s.br && e.zero && !e.ill;
        return e;
    endfunction

    function automatic stim_t op(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic br, input logic ordy);
        stim_t s;
        s.valid = 1'b1; s.flush = 1'b0; s.ordy = ordy;
        s.ctrl = c; s.a = a; s.b = b; s.br = br;
        s.sd = a ^ 32'h5A5A_0000; s.tgt = b + 32'h100; s.rd = a[AW-1:0] ^ 5'd3;
        s.rw = 1'b1; s.mr = c[0]; s.mw = c[1];
        return s;
    endfunction

    // Apply one cycle of stimulus, then advance the slot model past the clock edge.
    task automatic step(input stim_t s);
        logic exp_ready;
        in_valid_i = s.valid; flush_i = s.flush; out_ready_i = s.ordy;
        alu_ctrl_i = s.ctrl; src1_i = s.a; src2_i = s.b;
        store_data_i = s.sd; branch_target_i = s.tgt; rd_i = s.rd;
        reg_write_i = s.rw; mem_read_i = s.mr; mem_write_i = s.mw; branch_i = s.br;
        exp_ready = !slot_full || s.ordy;
        #1;
        check("in_ready", in_ready_o, exp_ready);
        @(posedge clk_i);
        #1;
        if (s.flush) begin
            exp_q.delete();
            slot_full = 1'b0;
        end else if (s.valid && exp_ready) begin
            exp_q.push_back(model(s));
            slot_full = 1'b1;
            accepted++;
        end else if (s.ordy) begin
            slot_full = 1'b0;
        end
    endtask

    // Monitor: every presented slot is compared against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("out_valid", out_valid_o, exp_q.size() != 0);
            if (out_valid_o && exp_q.size() != 0) begin
                check("result",    result_o,        exp_q[0].result);
                check("zero",      zero_o,          exp_q[0].zero);
                check("store",     store_data_o,    exp_q[0].sd);
                check("rd",        rd_o,            exp_q[0].rd);
                check("reg_write", reg_write_o,     exp_q[0].rw);
                check("mem_read",  mem_read_o,      exp_q[0].mr);
                check("mem_write", mem_write_o,     exp_q[0].mw);
                check("br_taken",  branch_taken_o,  exp_q[0].bt);
                check("br_target", branch_target_o, exp_q[0].tgt);
                check("illegal",   illegal_o,       exp_q[0].ill);
`ifdef EX_OVF_TRAP_EN
                check("ovf",       ovf_o,           exp_q[0].ovf);
`endif
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        stim_t       s;
        logic [3:0]  codes [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF};

        rst_i = 1'b1; in_valid_i = 0; flush_i = 0; out_ready_i = 0;
        alu_ctrl_i = 0; src1_i = 0; src2_i = 0; store_data_i = 0; branch_target_i = 0;
        rd_i = 0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; branch_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_illegal", illegal_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b1);
        rst_i = 1'b0;

        step(op(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1));
        check("add_wrap", result_o, 32'h8000_0000);
        step(op(4'h6, 32'd5, 32'd5, 1'b1, 1'b1));
        check("sub_zero", result_o, 32'h0);
        check("sub_zero_flag", zero_o, 1'b1);
        check("beq_taken", branch_taken_o, 1'b1);
        step(op(4'h7, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1));
        check("slt_neg", result_o, 32'h1);
        step(op(4'h7, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1));
        check("slt_pos", result_o, 32'h0);
        step(op(4'h0, 32'hF0F0, 32'h0FF0, 1'b0, 1'b1));
        check("and", result_o, 32'h00F0);
        step(op(4'h1, 32'hF0F0, 32'h0FF0, 1'b0, 1'b1));
        check("or", result_o, 32'hFFF0);
        step(op(4'hF, 32'h1234, 32'h1, 1'b1, 1'b1));
        check("illegal_flag", illegal_o, 1'b1);
        check("illegal_rw", reg_write_o, 1'b0);
        check("illegal_result", result_o, 32'h0);

        // Back-pressure: slot holds 3 while three ops are offered and refused.
        step(op(4'h2, 32'd1, 32'd2, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++) begin
            step(op(4'h2, 32'd10, 32'd20 + i, 1'b0, 1'b0));
            check("stall_hold", result_o, 32'd3);
        end
        for (int i = 1; i <= 3; i++) begin
            step(op(4'h2, 32'd100, i, 1'b0, 1'b1));
            check("b2b_result", result_o, 32'd100 + i);
        end

        // Flush with a full slot and an op on the input.
        step(op(4'h2, 32'd9, 32'd9, 1'b0, 1'b0));
        s = op(4'h2, 32'd50, 32'd50, 1'b0, 1'b0);
        s.flush = 1'b1;
        step(s);
        check("flush_valid", out_valid_o, 1'b0);

        // Reset while stalled with a full slot.
        step(op(4'h2, 32'd7, 32'd7, 1'b0, 1'b1));
        step(op(4'h2, 32'd8, 32'd8, 1'b0, 1'b0));
        in_valid_i = 1'b0;
        #1 rst_i = 1'b1;
        exp_q.delete();
        slot_full = 1'b0;
        #1;
        check("midrst_valid", out_valid_o, 1'b0);
        check("midrst_result", result_o, 32'h0);
        check("midrst_ready", in_ready_o, 1'b1);
        rst_i = 1'b0;

`ifdef EX_OVF_TRAP_EN
        step(op(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1));
        check("ovf_flag", ovf_o, 1'b1);
        check("ovf_rw", reg_write_o, 1'b0);
`endif

        for (int n = 0; n < 600; n++) begin
            s = op($urandom_range(0, 9) == 0 ? 4'($urandom) : codes[$urandom_range(0, 5)],
                   rand_operand(), rand_operand(), 1'($urandom), $urandom_range(0, 9) < 7);
            s.valid = $urandom_range(0, 3) != 0;
            s.flush = $urandom_range(0, 11) == 0;
            s.rd    = AW'($urandom);
            s.sd    = $urandom;
            s.tgt   = $urandom;
            s.rw    = 1'($urandom);
            s.mr    = 1'($urandom);
            s.mw    = 1'($urandom);
            step(s);
        end

        s = op(4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        s.valid = 1'b0;
        repeat (3) step(s);
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid", out_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage of the proj2 pipelined MIPS datapath, directly downstream of the ALU controller. Consumes the 4-bit ALU control code plus ID/EX operands and control bits, performs the ALU operation, resolves beq, and holds the result in a registered EX/MEM slot. Uses a valid/ready handshake so MEM can back-pressure, and supports a flush input from hazard logic.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register-file address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  squash incoming op and held slot
in_valid_i  in  1  ID/EX op present
in_ready_o  out  1  stage accepts op this cycle
alu_ctrl_i  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 invalid
src1_i  in  DATA_W  rs operand
src2_i  in  DATA_W  rt operand or sign-extended immediate
store_data_i  in  DATA_W  rt value for sw
rd_i  in  REG_AW  destination register
reg_write_i, mem_read_i, mem_write_i, branch_i  in  1 each  control bits
branch_target_i  in  DATA_W  precomputed PC+4+(imm<<2)
out_valid_o  out  1  EX/MEM slot holds a valid op
out_ready_i  in  1  MEM consumes slot
result_o  out  DATA_W  registered ALU result
zero_o  out  1  registered (result==0)
store_data_o  out  DATA_W  registered store data
rd_o  out  REG_AW  registered destination
reg_write_o, mem_read_o, mem_write_o  out  1 each  registered controls
branch_taken_o  out  1  registered branch_i & zero
branch_target_o  out  DATA_W  registered target
illegal_o  out  1  registered: op had alu_ctrl_i not in legal set

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0; all data outputs 0; all control outputs 0; illegal_o=0.
- in_ready_o = !out_valid_o | out_ready_i (combinational; full throughput, no bubble).
- Accept = in_valid_i & in_ready_o & !flush_i. On accept, all outputs load next cycle; out_valid_o=1. Latency 1 cycle.
- No accept and out_ready_i=1: out_valid_o -> 0 (slot drains). Out_valid_o=1 and out_ready_i=0: all outputs hold stable.
- flush_i=1: out_valid_o -> 0 next cycle, incoming op dropped, regardless of out_ready_i; flush wins over accept.
- ALU: AND/OR bitwise; ADD/SUB modulo 2^DATA_W (wrap, no trap by default); SLT signed compare, result {0..0, lt}.
- Codes outside legal set (incl. 1111): result=0, reg_write_o, mem_read_o, mem_write_o and branch_taken_o forced 0, illegal_o=1; op still occupies slot.
- zero_o from the computed result; branch_taken_o = branch_i & zero_o.
- Output controls valid only while out_valid_o=1; MEM must qualify with out_valid_o.
- Reset mid-stall: slot cleared, in_ready_o=1 after reset release.

Optional Feature:
EX_OVF_TRAP_EN: when defined, signed overflow on ADD/SUB sets ovf_o (extra 1-bit output, registered with slot, reset 0) and forces reg_write_o=0 for that op. When undefined, no ovf_o port; ADD/SUB wrap silently with normal writeback.

Decomposition:
- Shared package: ALU control code constants (AND, OR, ADD, SUB, SLT, INVALID), DATA_W/REG_AW defaults, EX/MEM payload struct typedef.
- One sub-module: alu_core (combinational ALU: ctrl, a, b -> result, zero, illegal, ovf). Stage keeps handshake and registers.

Test Plan:
- Reset: assert rst_i mid-cycle with slot full -> out_valid_o=0, result_o=0, in_ready_o=1 immediately.
- ADD 0x7FFFFFFF+1, SUB 5-5 with branch_i=1 -> result 0x80000000 one cycle later; next result 0, zero_o=1, branch_taken_o=1.
- SLT -1 vs 1 -> result_o=1; SLT 1 vs -1 -> 0; AND 0xF0F0&0x0FF0=0x00F0; OR -> 0xFFF0.
- Back-pressure: out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs frozen; release -> back-to-back accepts, one per cycle.
- Flush with in_valid_i=1, out_valid_o=1 -> next cycle out_valid_o=0, no op delivered.
- alu_ctrl_i=1111, reg_write_i=1 -> illegal_o=1, reg_write_o=0, result_o=0; with EX_OVF_TRAP_EN, ADD 0x7FFFFFFF+1 -> ovf_o=1, reg_write_o=0.
